// File: rtl/pc_unit_if.sv
// Next-PC control/status bundle between the fetch sequencer and pc_unit.
// The instret field is present only when PC_UNIT_INSTRET_EN is defined.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            en;
    logic [1:0]      sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] link_out;
    logic            misalign;
    logic            halted;
`ifdef PC_UNIT_INSTRET_EN
    logic [63:0]     instret;
`endif

    modport master (
        output en, sel, imm, base,
`ifdef PC_UNIT_INSTRET_EN
        input  instret,
`endif
        input  pc_out, pc_next, link_out, misalign, halted
    );

    modport slave (
        input  en, sel, imm, base,
`ifdef PC_UNIT_INSTRET_EN
        output instret,
`endif
        output pc_out, pc_next, link_out, misalign, halted
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with SEQ/BRANCH/JALR/TRAP next-PC selection and a RUN/HALT FSM that
// halts on misaligned targets. Define PC_UNIT_INSTRET_EN to add a 64-bit retired counter.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);
    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JALR   = 2'b10;
    localparam logic [1:0] SEL_TRAP   = 2'b11;

    typedef enum logic {StRun, StHalt} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    logic            halted_q;
    logic [XLEN-1:0] pc_next_c;
    logic [XLEN-1:0] jalr_sum;
    logic            tgt_misaligned;

    always_comb begin
        jalr_sum  = bus.base + bus.imm;
        pc_next_c = pc_q + XLEN'(4);
        case (bus.sel)
            SEL_SEQ:    pc_next_c = pc_q + XLEN'(4);
            SEL_BRANCH: pc_next_c = pc_q + (bus.imm << 1);
            SEL_JALR:   pc_next_c = {jalr_sum[XLEN-1:1], 1'b0};
            SEL_TRAP:   pc_next_c = TRAP_VECTOR;
            default:    pc_next_c = pc_q + XLEN'(4);
        endcase
    end

    // TRAP_VECTOR is trusted; only computed targets are checked for 4-byte alignment.
    assign tgt_misaligned = pc_next_c[1] && (bus.sel != SEL_TRAP);

`ifdef PC_UNIT_INSTRET_EN
    logic [63:0] instret_q;
    assign bus.instret = instret_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_UNIT_INSTRET_EN
            instret_q  <= '0;
`endif
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (bus.en) begin
                        if (tgt_misaligned) begin
                            state_q    <= StHalt;
                            misalign_q <= 1'b1;
                            halted_q   <= 1'b1;
                        end else begin
                            pc_q <= pc_next_c;
`ifdef PC_UNIT_INSTRET_EN
                            if (bus.sel != SEL_TRAP) instret_q <= instret_q + 64'd1;
`endif
                        end
                    end
                end
                StHalt: begin
                    if (bus.en && (bus.sel == SEL_TRAP)) begin
                        state_q  <= StRun;
                        pc_q     <= TRAP_VECTOR;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.pc_next  = pc_next_c;
    assign bus.link_out = pc_q + XLEN'(4);
    assign bus.misalign = misalign_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_pc_unit.sv
// Drives a 32-bit and a 64-bit pc_unit with identical directed and random stimulus and
// checks both against an arithmetic reference model of the next-PC rules.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) if32 ();
    pc_unit_if #(.XLEN(64)) if64 ();

    pc_unit #(.XLEN(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    pc_unit #(.XLEN(64), .RESET_VECTOR(64'h8000_0000)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mask   [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] rv     [2] = '{64'h0, 64'h8000_0000};
    logic [63:0] trap_v = 64'h100;
    logic [63:0] m_pc   [2];
    logic [63:0] m_ir   [2];
    bit          m_halt [2];
    bit          m_mis  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] target(input int i, input logic [1:0] s,
                                           input logic [63:0] im, input logic [63:0] b);
        logic [63:0] t;
        case (s)
            2'd0:    t = m_pc[i] + 64'd4;
            2'd1:    t = m_pc[i] + im * 64'd2;
            2'd2:    t = (b + im) & ~64'd1;
            default: t = trap_v;
        endcase
        return t & mask[i];
    endfunction

    // One clock: drive at negedge, check combinational outputs, then registered ones.
    task automatic step(input logic r, input logic e, input logic [1:0] s,
                        input logic [31:0] im, input logic [63:0] b);
        logic [63:0] im64;
        logic [63:0] tgt [2];
        logic [63:0] o_pc [2];
        logic [63:0] o_nx [2];
        logic [63:0] o_lk [2];
        logic [63:0] o_ir [2];
        bit          o_mis [2];
        bit          o_hlt [2];
        im64 = {{32{im[31]}}, im};
        @(negedge clk);
        rst = r;
        if32.en = e; if32.sel = s; if32.imm = im;         if32.base = b[31:0];
        if64.en = e; if64.sel = s; if64.imm = im64;       if64.base = b;
        #1;
        o_pc[0] = {32'b0, if32.pc_out};   o_pc[1] = if64.pc_out;
        o_nx[0] = {32'b0, if32.pc_next};  o_nx[1] = if64.pc_next;
        o_lk[0] = {32'b0, if32.link_out}; o_lk[1] = if64.link_out;
        for (int i = 0; i < 2; i++) begin
            tgt[i] = target(i, s, im64, b);
            check($sformatf("pc_hold%0d", i), o_pc[i], m_pc[i]);
            check($sformatf("pc_next%0d", i), o_nx[i], tgt[i]);
            check($sformatf("link%0d", i), o_lk[i], (m_pc[i] + 64'd4) & mask[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_pc[i] = rv[i]; m_halt[i] = 0; m_mis[i] = 0; m_ir[i] = 0;
            end else if (!m_halt[i]) begin
                m_mis[i] = 0;
                if (e) begin
                    if (s != 2'd3 && tgt[i][1]) begin
                        m_mis[i] = 1; m_halt[i] = 1;
                    end else begin
                        m_pc[i] = tgt[i];
                        if (s != 2'd3) m_ir[i] = m_ir[i] + 64'd1;
                    end
                end
            end else begin
                m_mis[i] = 0;
                if (e && s == 2'd3) begin
                    m_pc[i] = trap_v; m_halt[i] = 0;
                end
            end
        end
        o_pc[0] = {32'b0, if32.pc_out}; o_pc[1] = if64.pc_out;
        o_mis[0] = if32.misalign;       o_mis[1] = if64.misalign;
        o_hlt[0] = if32.halted;         o_hlt[1] = if64.halted;
`ifdef PC_UNIT_INSTRET_EN
        o_ir[0] = if32.instret;         o_ir[1] = if64.instret;
`else
        o_ir[0] = m_ir[0];              o_ir[1] = m_ir[1];
`endif
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pc_out%0d", i), o_pc[i], m_pc[i]);
            check($sformatf("misalign%0d", i), 64'(o_mis[i]), 64'(m_mis[i]));
            check($sformatf("halted%0d", i), 64'(o_hlt[i]), 64'(m_halt[i]));
`ifdef PC_UNIT_INSTRET_EN
            check($sformatf("instret%0d", i), o_ir[i], m_ir[i]);
`endif
        end
    endtask

    initial begin
        if32.en = 0; if32.sel = 0; if32.imm = 0; if32.base = 0;
        if64.en = 0; if64.sel = 0; if64.imm = 0; if64.base = 0;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = rv[i]; m_ir[i] = 0; m_halt[i] = 0; m_mis[i] = 0;
        end
        // Hold reset across the first edge so the model's starting state is established.
        @(posedge clk);
        #1;

        step(1, 0, 2'd0, 0, 0);
        check("reset_pc32", {32'b0, if32.pc_out}, 64'h0);
        check("reset_pc64", if64.pc_out, 64'h8000_0000);
        repeat (3) step(0, 1, 2'd0, 0, 0);
        check("seq_pc32", {32'b0, if32.pc_out}, 64'd12);
        check("seq_link32", {32'b0, if32.link_out}, 64'd16);
        check("seq_pc64", if64.pc_out, 64'h8000_000C);
        step(0, 1, 2'd0, 0, 0);
        repeat (2) step(0, 0, 2'd1, 32'd100, 0);
        check("stall_pc32", {32'b0, if32.pc_out}, 64'd16);
        step(0, 1, 2'd1, -32'sd4, 0);
        check("branch_back32", {32'b0, if32.pc_out}, 64'd8);
        check("branch_back64", if64.pc_out, 64'h8000_0008);

        // JALR to 0x1002 is not 4-byte aligned: the PC holds and the unit halts.
        step(0, 1, 2'd2, 32'd2, 64'h1001);
        check("jalr_hold32", {32'b0, if32.pc_out}, 64'd8);
        check("jalr_halt32", 64'(if32.halted), 64'd1);
        check("jalr_mis32", 64'(if32.misalign), 64'd1);
        repeat (2) step(0, 1, 2'd0, 0, 0);
        step(0, 1, 2'd3, 0, 0);
        check("trap_pc32", {32'b0, if32.pc_out}, 64'h100);
        check("trap_halt32", 64'(if32.halted), 64'd0);

        step(0, 1, 2'd1, -32'sd130, 0);
        check("near_wrap32", {32'b0, if32.pc_out}, 64'hFFFF_FFFC);
        step(0, 1, 2'd0, 0, 0);
        check("wrap32", {32'b0, if32.pc_out}, 64'h0);

        step(0, 1, 2'd2, 32'd2, 64'h1001);
        step(1, 0, 2'd0, 0, 0);
        check("halt_reset64", if64.pc_out, 64'h8000_0000);
        check("halt_reset_h64", 64'(if64.halted), 64'd0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] im;
            im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), im, {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
